// File: rtl/ddr3_ring_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ddr3_ring_sequencer: ring-buffered burst sequencer, USB FIFOs <-> MIG app |
// | Optional stats counters: define DDR3_SEQ_STATS_EN.  Rev 1.0               |
// +---------------------------------------------------------------------------+
module ddr3_ring_sequencer #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256,
  parameter int BURST_MAX  = 16,
  parameter int RING_BASE  = 0,
  parameter int RING_BEATS = 1024,
  parameter int ADDR_STEP  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init_calib_complete,
  input  logic [1:0]                      mode,
  input  logic [$clog2(BURST_MAX+1)-1:0]  burst_len,
  input  logic [DATA_WIDTH-1:0]           in_dout,
  input  logic [15:0]                     in_count,
  output logic                            in_rd_en,
  output logic [DATA_WIDTH-1:0]           out_din,
  output logic                            out_wr_en,
  input  logic [15:0]                     out_free,
  output logic [ADDR_WIDTH-1:0]           app_addr,
  output logic [2:0]                      app_cmd,
  output logic                            app_en,
  input  logic                            app_rdy,
  output logic [DATA_WIDTH-1:0]           app_wdf_data,
  output logic                            app_wdf_wren,
  output logic                            app_wdf_end,
  input  logic                            app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]           app_rd_data,
  input  logic                            app_rd_data_valid,
  output logic [$clog2(RING_BEATS):0]     level,
  output logic                            busy,
  output logic [31:0]                     stat_wr_bursts,
  output logic [31:0]                     stat_rd_bursts,
  output logic [31:0]                     stat_stalls
);
  localparam int BL_W  = $clog2(BURST_MAX+1);
  localparam int PTR_W = $clog2(RING_BEATS);
  localparam int LVL_W = PTR_W + 1;
  localparam int CMP_W = ((LVL_W > 16) ? LVL_W : 16) + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_WR   = 2'd2,
    S_RD   = 2'd3
  } state_t;

  state_t             r_state;
  logic [BL_W-1:0]    r_len;
  logic [BL_W-1:0]    r_cmd_cnt;
  logic [BL_W-1:0]    r_data_cnt;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [LVL_W-1:0]   r_rd_out;
  logic [LVL_W-1:0]   r_wr_inflight;
  logic               r_last_rd;

  logic [BL_W-1:0]    w_len;
  logic [CMP_W-1:0]   w_ring_free;
  logic               w_wr_elig;
  logic               w_rd_elig;
  logic [PTR_W-1:0]   w_ptr;
  logic               w_acc;
  logic               w_push;
  logic [BL_W-1:0]    w_cmd_nxt;
  logic [BL_W-1:0]    w_data_nxt;
  logic               w_wr_done;
  logic               w_rd_done;

  assign w_len = (burst_len == '0) ? BL_W'(1) :
                 (burst_len > BL_W'(BURST_MAX)) ? BL_W'(BURST_MAX) : burst_len;

  assign w_ring_free = CMP_W'(RING_BEATS) - CMP_W'(r_level) - CMP_W'(r_wr_inflight);
  assign w_wr_elig   = mode[0] && (CMP_W'(in_count) >= CMP_W'(w_len)) &&
                       (w_ring_free >= CMP_W'(w_len));
  assign w_rd_elig   = mode[1] && (CMP_W'(r_level) >= CMP_W'(w_len)) &&
                       (CMP_W'(out_free) >= CMP_W'(w_len) + CMP_W'(r_rd_out));

  assign busy         = (r_state == S_WR) || (r_state == S_RD);
  assign app_en       = busy && (r_cmd_cnt < r_len);
  assign app_wdf_wren = (r_state == S_WR) && (r_data_cnt < r_len);
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = in_dout;
  assign in_rd_en     = app_wdf_wren && app_wdf_rdy;
  assign app_cmd      = (r_state == S_RD) ? 3'b001 : 3'b000;
  assign w_ptr        = (r_state == S_RD) ? r_rd_ptr : r_wr_ptr;
  assign app_addr     = app_en ? (ADDR_WIDTH'(RING_BASE) +
                                  ADDR_WIDTH'(w_ptr) * ADDR_WIDTH'(ADDR_STEP)) : '0;
  assign level        = r_level;

  // Returns are only forwarded for reads this instance actually issued.
  assign w_push    = app_rd_data_valid && (r_rd_out != '0);
  assign out_wr_en = w_push;
  assign out_din   = app_rd_data;

  assign w_acc      = app_en && app_rdy;
  assign w_cmd_nxt  = r_cmd_cnt + BL_W'(w_acc);
  assign w_data_nxt = r_data_cnt + BL_W'(in_rd_en);
  assign w_wr_done  = (w_cmd_nxt == r_len) && (w_data_nxt == r_len);
  assign w_rd_done  = (w_cmd_nxt == r_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_cmd_cnt     <= '0;
      r_data_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_rd_out      <= '0;
      r_wr_inflight <= '0;
      r_last_rd     <= 1'b0;
    end else begin
      r_rd_out <= r_rd_out + LVL_W'(w_acc && (r_state == S_RD)) - LVL_W'(w_push);
      case (r_state)
        S_IDLE: if (init_calib_complete) r_state <= S_ARB;
        S_ARB: begin
          r_cmd_cnt  <= '0;
          r_data_cnt <= '0;
          r_len      <= w_len;
          if (!init_calib_complete) begin
            r_state <= S_IDLE;
          end else if (w_wr_elig && (!w_rd_elig || r_last_rd)) begin
            r_state       <= S_WR;
            r_wr_inflight <= LVL_W'(w_len);
            r_last_rd     <= 1'b0;
          end else if (w_rd_elig) begin
            r_state   <= S_RD;
            r_last_rd <= 1'b1;
          end
        end
        S_WR: begin
          r_cmd_cnt  <= w_cmd_nxt;
          r_data_cnt <= w_data_nxt;
          if (w_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          // Commit the whole burst at once so readers never see partial data.
          if (w_wr_done) begin
            r_level       <= r_level + LVL_W'(r_len);
            r_wr_inflight <= '0;
            r_state       <= S_ARB;
          end
        end
        S_RD: begin
          r_cmd_cnt <= w_cmd_nxt;
          if (w_acc) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level  <= r_level - LVL_W'(1);
          end
          if (w_rd_done) r_state <= S_ARB;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DDR3_SEQ_STATS_EN
  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_st;
  logic        w_stall;

  assign w_stall = busy && ((app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_wr <= '0;
      r_stat_rd <= '0;
      r_stat_st <= '0;
    end else begin
      if ((r_state == S_WR) && w_wr_done && (r_stat_wr != '1)) r_stat_wr <= r_stat_wr + 32'd1;
      if ((r_state == S_RD) && w_acc && w_rd_done && (r_stat_rd != '1)) r_stat_rd <= r_stat_rd + 32'd1;
      if (w_stall && (r_stat_st != '1)) r_stat_st <= r_stat_st + 32'd1;
    end
  end

  assign stat_wr_bursts = r_stat_wr;
  assign stat_rd_bursts = r_stat_rd;
  assign stat_stalls    = r_stat_st;
`else
  assign stat_wr_bursts = '0;
  assign stat_rd_bursts = '0;
  assign stat_stalls    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ring_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ddr3_ring_sequencer: FIFO/MIG environment model with ring checks       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_ddr3_ring_sequencer;
  localparam int AW   = 29;
  localparam int DW   = 32;
  localparam int BM   = 16;
  localparam int BASE = 0;
  localparam int RB   = 16;
  localparam int AS   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [4:0]    burst_len = 5'd0;
  logic [DW-1:0] in_dout = '0;
  logic [15:0]   in_count = '0;
  logic [15:0]   out_free = 16'd64;
  logic          app_rdy = 1'b0;
  logic          app_wdf_rdy = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;

  logic          in_rd_en, out_wr_en, app_en, app_wdf_wren, app_wdf_end, busy;
  logic [DW-1:0] out_din, app_wdf_data;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic [4:0]    level;
  logic [31:0]   stat_wr_bursts, stat_rd_bursts, stat_stalls;

  ddr3_ring_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM),
    .RING_BASE(BASE), .RING_BEATS(RB), .ADDR_STEP(AS)
  ) dut (
    .clk(clk), .reset(reset), .init_calib_complete(init), .mode(mode),
    .burst_len(burst_len), .in_dout(in_dout), .in_count(in_count),
    .in_rd_en(in_rd_en), .out_din(out_din), .out_wr_en(out_wr_en),
    .out_free(out_free), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .level(level), .busy(busy),
    .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts),
    .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Environment: ingress FWFT FIFO, DDR3 memory with read latency, egress sink.
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] egress_q[$];
  logic [AW-1:0] wcmd_q[$];
  logic [DW-1:0] wdat_q[$];
  logic [DW-1:0] rdq_data[$];
  int            rdq_due[$];
  logic [DW-1:0] mem [int];
  int cyc = 0, wr_idx = 0, rd_idx = 0, pops = 0, pushes = 0, stalls = 0;
  int first_wcmd = 0, last_wcmd = 0, max_level = 0;
  int rdy_mode = 0, lat_min = 1, lat_max = 4;
  logic p_pop = 0, p_wdat = 0, p_wcmd = 0, p_rcmd = 0, p_push = 0;
  logic [DW-1:0] p_wdat_v = '0, p_rdat = '0, p_push_v = '0;
  logic [AW-1:0] p_waddr = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (p_pop && in_q.size() > 0) void'(in_q.pop_front());
      if (p_wdat) wdat_q.push_back(p_wdat_v);
      if (p_wcmd) wcmd_q.push_back(p_waddr);
      while (wcmd_q.size() > 0 && wdat_q.size() > 0) mem[int'(wcmd_q.pop_front())] = wdat_q.pop_front();
      if (p_rcmd) begin
        rdq_data.push_back(p_rdat);
        rdq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
      if (p_push) begin egress_q.push_back(p_push_v); pushes++; end

      case (rdy_mode)
        1:       begin app_rdy = ($urandom_range(9, 0) < 7); app_wdf_rdy = ($urandom_range(9, 0) < 7); end
        2:       begin app_rdy = (cyc % 4 == 0); app_wdf_rdy = 1'b1; end
        default: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
      endcase
      in_count = 16'(in_q.size());
      in_dout  = (in_q.size() > 0) ? in_q[0] : '0;
      if (rdq_due.size() > 0 && rdq_due[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = rdq_data.pop_front();
        void'(rdq_due.pop_front());
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data = DW'($urandom);
      end

      #1;
      p_pop    = in_rd_en;
      p_wdat   = app_wdf_wren && app_wdf_rdy && !reset;
      p_wdat_v = app_wdf_data;
      p_wcmd   = app_en && app_rdy && (app_cmd == 3'b000) && !reset;
      p_waddr  = app_addr;
      p_rcmd   = app_en && app_rdy && (app_cmd == 3'b001);
      p_rdat   = mem.exists(int'(app_addr)) ? mem[int'(app_addr)] : '0;
      p_push   = out_wr_en;
      p_push_v = out_din;
      if (p_pop) pops++;
      if (int'(level) > max_level) max_level = int'(level);
      if (reset) begin
        wr_idx = 0; rd_idx = 0; stalls = 0;
        wcmd_q.delete(); wdat_q.delete();
      end else begin
        if ((app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy)) stalls++;
        if (p_wcmd) begin
          chk("wr_addr", 64'(app_addr), 64'(AW'(BASE + (wr_idx % RB) * AS)));
          if (wr_idx == 0) first_wcmd = cyc;
          last_wcmd = cyc;
          wr_idx++;
        end
        if (p_rcmd) begin
          chk("rd_addr", 64'(app_addr), 64'(AW'(BASE + (rd_idx % RB) * AS)));
          rd_idx++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; init = 1'b0; mode = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    in_q.delete(); exp_q.delete(); egress_q.delete();
    max_level = 0;
  endtask

  task automatic load(input int n);
    @(negedge clk);
    #3;
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      in_q.push_back(v);
      exp_q.push_back(v);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic check_egress(input string tag);
    chk({tag, "_count"}, 64'(egress_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < egress_q.size(); i++)
      chk({tag, "_beat"}, 64'(egress_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int n;
    int p0;
    // Reset state
    settle(3);
    chk("rst_app_en", 64'(app_en), 0);
    chk("rst_wren", 64'(app_wdf_wren), 0);
    chk("rst_in_rd_en", 64'(in_rd_en), 0);
    chk("rst_out_wr_en", 64'(out_wr_en), 0);
    chk("rst_cmd", 64'(app_cmd), 0);
    chk("rst_addr", 64'(app_addr), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_stats", 64'(stat_wr_bursts | stat_rd_bursts | stat_stalls), 0);

    // Write-only, L=4, 8 beats, no stalls
    do_reset(); rdy_mode = 0; p0 = pops;
    load(8);
    init = 1'b1; mode = 2'b01; burst_len = 5'd4;
    n = 0; while (wr_idx < 8 && n < 200) begin @(negedge clk); n++; end
    settle(20);
    chk("wo_cmds", 64'(wr_idx), 8);
    chk("wo_pops", 64'(pops - p0), 8);
    chk("wo_level", 64'(level), 8);
    chk("wo_busy", 64'(busy), 0);
    chk("wo_span", 64'(last_wcmd - first_wcmd), 8);
    for (int i = 0; i < 8; i++)
      chk("wo_mem", 64'(mem.exists(i * AS) ? mem[i * AS] : '0), 64'(exp_q[i]));

    // Ring full: 20 beats offered into a 16-beat ring
    do_reset(); p0 = pops;
    load(20);
    init = 1'b1; mode = 2'b01; burst_len = 5'd4;
    settle(150);
    chk("full_level", 64'(level), 16);
    chk("full_cmds", 64'(wr_idx), 16);
    chk("full_pops", 64'(pops - p0), 16);
    chk("full_left", 64'(in_q.size()), 4);
    chk("full_max", 64'(max_level), 16);

    // Loopback 40 beats, random ready and latency, pointers wrap
    do_reset(); rdy_mode = 1; lat_min = 1; lat_max = 6;
    load(40);
    init = 1'b1; mode = 2'b11; burst_len = 5'd4;
    n = 0; while (egress_q.size() < 40 && n < 3000) begin @(negedge clk); n++; end
    settle(10);
    check_egress("lb");
    chk("lb_level", 64'(level), 0);
    chk("lb_rd_cmds", 64'(rd_idx), 40);
    chk("lb_max", 64'(max_level <= RB), 1);
`ifdef DDR3_SEQ_STATS_EN
    chk("lb_stat_wr", 64'(stat_wr_bursts), 10);
    chk("lb_stat_rd", 64'(stat_rd_bursts), 10);
`else
    chk("lb_stat_wr", 64'(stat_wr_bursts), 0);
    chk("lb_stat_rd", 64'(stat_rd_bursts), 0);
`endif

    // app_rdy high one cycle in four during WR
    do_reset(); rdy_mode = 2; p0 = pops;
    load(8);
    init = 1'b1; mode = 2'b01; burst_len = 5'd4;
    n = 0; while (wr_idx < 8 && n < 300) begin @(negedge clk); n++; end
    settle(10);
    chk("st_cmds", 64'(wr_idx), 8);
    chk("st_pops", 64'(pops - p0), 8);
    chk("st_level", 64'(level), 8);
    chk("st_seen", 64'(stalls > 0), 1);
`ifdef DDR3_SEQ_STATS_EN
    chk("st_stalls", 64'(stat_stalls), 64'(stalls));
    chk("st_bursts", 64'(stat_wr_bursts), 2);
`else
    chk("st_stalls", 64'(stat_stalls), 0);
`endif

    // burst_len=0 behaves as 1
    do_reset(); rdy_mode = 0; lat_min = 1; lat_max = 3;
    load(5);
    init = 1'b1; mode = 2'b11; burst_len = 5'd0;
    n = 0; while (egress_q.size() < 5 && n < 300) begin @(negedge clk); n++; end
    settle(5);
    check_egress("l0");
    chk("l0_level", 64'(level), 0);

    // burst_len=25 clamps to 16: 15 beats are not enough, 16 are
    do_reset();
    load(15);
    init = 1'b1; mode = 2'b11; burst_len = 5'd25;
    settle(40);
    chk("cl_short", 64'(wr_idx), 0);
    load(1);
    n = 0; while (egress_q.size() < 16 && n < 400) begin @(negedge clk); n++; end
    settle(5);
    check_egress("cl");
    chk("cl_wr_cmds", 64'(wr_idx), 16);

    // Reset in the middle of a read burst with 3 reads outstanding
    do_reset(); rdy_mode = 0; lat_min = 25; lat_max = 25;
    load(8);
    init = 1'b1; mode = 2'b11; burst_len = 5'd4;
    n = 0;
    while (rd_idx < 3 && n < 200) begin @(negedge clk); #2; n++; end
    chk("mr_reached", 64'(rd_idx), 3);
    @(negedge clk);
    reset = 1'b1; init = 1'b0; p0 = pushes;
    settle(1);
    chk("mr_app_en", 64'(app_en), 0);
    chk("mr_wren", 64'(app_wdf_wren), 0);
    chk("mr_in_rd_en", 64'(in_rd_en), 0);
    chk("mr_out_wr_en", 64'(out_wr_en), 0);
    chk("mr_busy", 64'(busy), 0);
    chk("mr_level", 64'(level), 0);
    chk("mr_addr", 64'(app_addr), 0);
    reset = 1'b0;
    settle(40);
    chk("mr_dropped", 64'(pushes - p0), 0);
    chk("mr_drained", 64'(rdq_due.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
